pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 16, range 2..255: the maximum number of MEM_WAIT cycles before a timeout.
REQ-002 The block SHALL use one clock, clk; reset is synchronous and active-high, rst.
REQ-003 Ports SHALL be, in this order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- IFID_rs1  in  5  source register 1 of the instruction in ID
- IFID_rs2  in  5  source register 2 of the instruction in ID
- IDEX_rd  in  5  destination register of the instruction in EX
- IDEX_MemoryRead  in  1  the instruction in EX is a load
- EX_branch_taken  in  1  a branch or jump resolved taken in EX
- MEM_req  in  1  a data-memory access is issued from MEM this cycle
- MEM_ack  in  1  data memory has completed the access
- pc_write  out  1  PC update enable
- IFID_write  out  1  IF/ID register load enable
- IFID_flush  out  1  clears IF/ID to a NOP
- IDEX_bubble  out  1  loads all-zero controls into ID/EX
- IDEX_hold  out  1  freezes ID/EX
- EXMEM_hold  out  1  freezes EX/MEM
- wait_timeout  out  1  sticky memory-timeout error

Function
REQ-004 The FSM SHALL have three states, RUN, MEM_WAIT and ERROR, encoded in 2 bits.
REQ-005 RUN default outputs SHALL be: pc_write=1, IFID_write=1, all other outputs 0.
REQ-006 RUN, priority 1: if MEM_req=1 and MEM_ack=0, the block SHALL go to MEM_WAIT next cycle.
- Freeze this cycle: pc_write=0, IFID_write=0, IDEX_hold=1, EXMEM_hold=1, no bubble.
- If EX_branch_taken=1 in the same cycle, set pending_flush=1.
REQ-007 RUN, priority 2: if EX_branch_taken=1, the block SHALL assert IFID_flush=1 and IDEX_bubble=1 in the same cycle, with pc_write=1.
REQ-008 RUN, priority 3 (load-use): if IDEX_MemoryRead=1, IDEX_rd!=0, and IDEX_rd equals IFID_rs1 or IFID_rs2, the block SHALL assert pc_write=0, IFID_write=0 and IDEX_bubble=1 for exactly that cycle.
REQ-009 MEM_req=1 with MEM_ack=1 in the same cycle SHALL be treated as a zero-wait access: no freeze, and RUN priorities 2 and 3 apply.
REQ-010 In MEM_WAIT with MEM_ack=0, the block SHALL hold the freeze outputs and increment wait_cnt (8 bits, saturating).
REQ-011 In MEM_WAIT with MEM_ack=0, EX_branch_taken=1 SHALL set pending_flush.
REQ-012 On MEM_ack=1 in MEM_WAIT, that cycle's outputs SHALL be RUN outputs with priority 1 ignored.
- If pending_flush=1, the flush action of REQ-007 applies, overriding load-use.
- Next state is RUN; wait_cnt and pending_flush clear.
REQ-013 When wait_cnt reaches MAX_WAIT-1 with MEM_ack=0, the block SHALL go to ERROR next cycle.
REQ-014 In ERROR, the block SHALL hold the freeze outputs and assert wait_timeout=1; all inputs are ignored and only rst exits ERROR.
REQ-015 MEM_ack outside MEM_WAIT, other than the case in REQ-009, SHALL be ignored.
REQ-016 All outputs SHALL be combinational from the state, the registered flags and the current inputs; detection-to-action latency is 0 cycles.

Reset
REQ-017 While rst=1, outputs SHALL be pc_write=0, IFID_write=0, IFID_flush=1, IDEX_bubble=1, IDEX_hold=0, EXMEM_hold=0 and wait_timeout=0.
REQ-018 On rst=1, the next state SHALL be RUN, with wait_cnt=0, pending_flush=0 and perf counters=0.
REQ-019 rst SHALL abort MEM_WAIT or ERROR, and SHALL take precedence over all inputs.

Configuration
REQ-020 With HAZARD_PERF_CNT_EN defined, three 32-bit wrapping output ports SHALL be added:
- stall_cycles: counts cycles with pc_write=0 while rst=0.
- flush_count: counts cycles with IFID_flush=1 while rst=0.
- loaduse_count: counts cycles where the load-use action of REQ-008 is taken.
REQ-021 Without HAZARD_PERF_CNT_EN, these ports and their counters SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-022 The state encoding (RUN=0, MEM_WAIT=1, ERROR=2) and the MAX_WAIT default SHALL reside in the shared package hazard_pkg.
REQ-023 The load-use comparator SHALL be a sub-module, load_use_detect, that is purely combinational.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Load-use: IDEX_MemoryRead=1, IDEX_rd=5, IFID_rs2=5 -> exactly one cycle of pc_write=0, IFID_write=0, IDEX_bubble=1.
- Register x0 exempt: IDEX_rd=0, IFID_rs1=0, IDEX_MemoryRead=1 -> no stall.
- Branch beats load-use: EX_branch_taken=1 together with a load-use hit -> IFID_flush=1, IDEX_bubble=1, pc_write=1.
- Memory wait with branch: MEM_req=1, MEM_ack low for 3 cycles, EX_branch_taken=1 -> freeze for 4 cycles (including the request cycle); flush in the ack cycle; RUN next.
- Timeout: MEM_req=1, no ack, MAX_WAIT=4 -> ERROR with wait_timeout=1 after 5 cycles; rst for 1 cycle -> RUN, all flags cleared.
- Perf counters (HAZARD_PERF_CNT_EN): one load-use hit plus two branches -> stall_cycles=1, flush_count=2, loaduse_count=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared definitions for the pipeline hazard controller.
//   hazard_state_e   : controller FSM state encoding (RUN=0, MEM_WAIT=1, ERROR=2)
//   MAX_WAIT_DEFAULT : default memory-wait budget before a timeout is declared
//   WAIT_CNT_W       : width of the memory-wait cycle counter
//   sat_inc8()       : saturating increment for the 8-bit wait counter
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hazard_state_e;

    localparam int unsigned MAX_WAIT_DEFAULT = 32'd16;
    localparam int unsigned WAIT_CNT_W       = 32'd8;

    // Saturating +1 so a stuck counter can never wrap back below the limit.
    function automatic logic [WAIT_CNT_W-1:0] sat_inc8(input logic [WAIT_CNT_W-1:0] v);
        logic [WAIT_CNT_W-1:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect -- purely combinational load-use hazard comparator.
//   memread_i : instruction in EX is a load
//   ex_rd_i   : destination register of the instruction in EX
//   id_rs1_i  : source register 1 of the instruction in ID
//   id_rs2_i  : source register 2 of the instruction in ID
//   hit_o     : ID consumes the load result one cycle too early
// Register x0 is hard-wired to zero, so a load targeting it never creates a hazard.
module load_use_detect (
    input  logic       memread_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    output logic       hit_o
);

    assign hit_o = memread_i && (ex_rd_i != 5'd0) &&
                   ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl -- stall/flush/freeze controller for a 5-stage pipeline.
// Handles load-use stalls, taken-branch flushes and multi-cycle data-memory
// waits with a sticky timeout. All outputs are combinational (zero latency).
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   IFID_rs1/rs2       : ID-stage source registers
//   IDEX_rd            : EX-stage destination register
//   IDEX_MemoryRead    : EX-stage instruction is a load
//   EX_branch_taken    : branch/jump resolved taken in EX
//   MEM_req / MEM_ack  : data-memory request from MEM / completion
//   pc_write, IFID_write, IFID_flush, IDEX_bubble, IDEX_hold, EXMEM_hold :
//                        pipeline register controls
//   wait_timeout       : sticky memory-timeout error (cleared only by rst)
//
// Optional build macro HAZARD_PERF_CNT_EN adds three 32-bit wrapping counters:
//   stall_cycles, flush_count, loaduse_count.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IFID_rs1,
    input  logic [4:0]  IFID_rs2,
    input  logic [4:0]  IDEX_rd,
    input  logic        IDEX_MemoryRead,
    input  logic        EX_branch_taken,
    input  logic        MEM_req,
    input  logic        MEM_ack,
    output logic        pc_write,
    output logic        IFID_write,
    output logic        IFID_flush,
    output logic        IDEX_bubble,
    output logic        IDEX_hold,
    output logic        EXMEM_hold,
    output logic        wait_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [31:0] loaduse_count
`endif
);

    // The last MEM_WAIT cycle allowed before the controller gives up.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT - 32'd1);

    hazard_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    pending_flush_q, pending_flush_d;
    logic                    lu_hit_s;

    load_use_detect u_lud (
        .memread_i (IDEX_MemoryRead),
        .ex_rd_i   (IDEX_rd),
        .id_rs1_i  (IFID_rs1),
        .id_rs2_i  (IFID_rs2),
        .hit_o     (lu_hit_s)
    );

    // State, wait counter and deferred-flush flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            wait_cnt_q      <= 8'd0;
            pending_flush_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            pending_flush_q <= pending_flush_d;
        end
    end

    // Next-state and pipeline control outputs.
    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        pending_flush_d = pending_flush_q;
        pc_write        = 1'b0;
        IFID_write      = 1'b0;
        IFID_flush      = 1'b0;
        IDEX_bubble     = 1'b0;
        IDEX_hold       = 1'b0;
        EXMEM_hold      = 1'b0;
        wait_timeout    = 1'b0;

        if (rst) begin
            // Squash IF/ID and ID/EX while the pipeline is being reset.
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (MEM_req && !MEM_ack) begin
                        // Freeze the whole front of the pipe; a branch taken now
                        // is remembered and applied when memory completes.
                        IDEX_hold       = 1'b1;
                        EXMEM_hold      = 1'b1;
                        state_d         = ST_MEM_WAIT;
                        wait_cnt_d      = 8'd0;
                        pending_flush_d = EX_branch_taken;
                    end else if (EX_branch_taken) begin
                        pc_write    = 1'b1;
                        IFID_write  = 1'b1;
                        IFID_flush  = 1'b1;
                        IDEX_bubble = 1'b1;
                    end else if (lu_hit_s) begin
                        IDEX_bubble = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        IFID_write = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (MEM_ack) begin
                        state_d         = ST_RUN;
                        wait_cnt_d      = 8'd0;
                        pending_flush_d = 1'b0;
                        if (pending_flush_q || EX_branch_taken) begin
                            pc_write    = 1'b1;
                            IFID_write  = 1'b1;
                            IFID_flush  = 1'b1;
                            IDEX_bubble = 1'b1;
                        end else if (lu_hit_s) begin
                            IDEX_bubble = 1'b1;
                        end else begin
                            pc_write   = 1'b1;
                            IFID_write = 1'b1;
                        end
                    end else begin
                        IDEX_hold  = 1'b1;
                        EXMEM_hold = 1'b1;
                        wait_cnt_d = sat_inc8(wait_cnt_q);
                        if (EX_branch_taken) begin
                            pending_flush_d = 1'b1;
                        end else begin
                            pending_flush_d = pending_flush_q;
                        end
                        if (wait_cnt_q == WAIT_LIMIT) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d = ST_MEM_WAIT;
                        end
                    end
                end
                ST_ERROR: begin
                    IDEX_hold    = 1'b1;
                    EXMEM_hold   = 1'b1;
                    wait_timeout = 1'b1;
                end
                default: begin
                    // Unreachable encoding: freeze and recover to RUN.
                    IDEX_hold  = 1'b1;
                    EXMEM_hold = 1'b1;
                    state_d    = ST_RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, flush_count_q, loaduse_count_q;
    logic        lu_taken_s;

    // A bubble without a flush is only ever produced by the load-use action.
    assign lu_taken_s = IDEX_bubble && !IFID_flush && !rst;

    // Wrapping performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q  <= 32'd0;
            flush_count_q   <= 32'd0;
            loaduse_count_q <= 32'd0;
        end else begin
            stall_cycles_q  <= stall_cycles_q  + {31'd0, !pc_write};
            flush_count_q   <= flush_count_q   + {31'd0, IFID_flush};
            loaduse_count_q <= loaduse_count_q + {31'd0, lu_taken_s};
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign flush_count   = flush_count_q;
    assign loaduse_count = loaduse_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized cycles compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int MAX_W = 4;

    // Output vector order: {pc_write, IFID_write, IFID_flush, IDEX_bubble,
    //                       IDEX_hold, EXMEM_hold, wait_timeout}
    localparam logic [6:0] RUN_O   = 7'b1100000;
    localparam logic [6:0] FRZ_O   = 7'b0000110;
    localparam logic [6:0] FLUSH_O = 7'b1111000;
    localparam logic [6:0] LU_O    = 7'b0001000;
    localparam logic [6:0] RST_O   = 7'b0011000;
    localparam logic [6:0] ERR_O   = 7'b0000111;

    logic       clk;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       memrd, br, req, ack;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold, wait_timeout;
    logic [6:0] outs;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count, loaduse_count;
`endif

    int n_cmp;
    int n_err;

    // Reference model state
    bit          m_wait, m_err, m_pend;
    int          m_waited;
    int unsigned m_stall, m_flush, m_lu;

    pipeline_hazard_ctrl #(.MAX_WAIT(MAX_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .IFID_rs1        (rs1),
        .IFID_rs2        (rs2),
        .IDEX_rd         (rd),
        .IDEX_MemoryRead (memrd),
        .EX_branch_taken (br),
        .MEM_req         (req),
        .MEM_ack         (ack),
        .pc_write        (pc_write),
        .IFID_write      (ifid_write),
        .IFID_flush      (ifid_flush),
        .IDEX_bubble     (idex_bubble),
        .IDEX_hold       (idex_hold),
        .EXMEM_hold      (exmem_hold),
        .wait_timeout    (wait_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .loaduse_count   (loaduse_count)
`endif
    );

    assign outs = {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold, wait_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs this cycle, from the rules and the model's memory of the past.
    function automatic logic [6:0] model_out();
        bit lu;
        lu = memrd && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
        if (rst)                       return RST_O;
        if (m_err)                     return ERR_O;
        if (m_wait && !ack)            return FRZ_O;
        if (!m_wait && req && !ack)    return FRZ_O;
        if (br || (m_wait && m_pend))  return FLUSH_O;
        if (lu)                        return LU_O;
        return RUN_O;
    endfunction

    task automatic set_in(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d, input logic mr, input logic b,
                          input logic rq, input logic ak);
        rst = r; rs1 = s1; rs2 = s2; rd = d; memrd = mr; br = b; req = rq; ack = ak;
        #1;
    endtask

    // Advance the model by one clock using the current inputs, then advance the DUT.
    task automatic tick();
        logic [6:0] o;
        o = model_out();
        if (rst) begin
            m_stall = 0; m_flush = 0; m_lu = 0;
            m_wait = 0; m_err = 0; m_pend = 0; m_waited = 0;
        end else begin
            if (!o[6])       m_stall++;
            if (o[4])        m_flush++;
            if (o == LU_O)   m_lu++;
            if (m_err) begin
                m_err = 1;
            end else if (m_wait) begin
                if (ack) begin
                    m_wait = 0; m_pend = 0;
                end else begin
                    m_waited++;
                    if (br) m_pend = 1;
                    if (m_waited >= MAX_W) m_err = 1;
                end
            end else if (req && !ack) begin
                m_wait = 1; m_waited = 0; m_pend = br;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        m_wait = 0; m_err = 0; m_pend = 0; m_waited = 0;
        m_stall = 0; m_flush = 0; m_lu = 0;

        // Reset outputs
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reset_out", 32'(outs), 32'(RST_O));
        tick(); tick();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("run_idle", 32'(outs), 32'(RUN_O));

        // Load-use: exactly one stall cycle
        set_in(1'b0, 5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("loaduse", 32'(outs), 32'(LU_O));
        tick();
        set_in(1'b0, 5'd3, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("loaduse_one", 32'(outs), 32'(RUN_O));

        // x0 exempt
        set_in(1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("x0_exempt", 32'(outs), 32'(RUN_O));

        // Branch beats load-use
        set_in(1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("branch_over_lu", 32'(outs), 32'(FLUSH_O));
        tick();

        // Zero-wait access: no freeze, load-use still applies
        set_in(1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("zero_wait_lu", 32'(outs), 32'(LU_O));
        tick();

        // Memory wait with a branch: 4 freeze cycles, flush on ack, then RUN
        set_in(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("memwait_req", 32'(outs), 32'(FRZ_O));
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
            check_eq("memwait_hold", 32'(outs), 32'(FRZ_O));
            tick();
        end
        set_in(1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("memwait_ack_flush", 32'(outs), 32'(FLUSH_O));
        tick();
        set_in(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("memwait_run", 32'(outs), 32'(RUN_O));
        tick();

        // Timeout with MAX_WAIT=4: ERROR 5 cycles after the request
        set_in(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("to_req", 32'(outs), 32'(FRZ_O));
        tick();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
            check_eq("to_wait", 32'(outs), 32'(FRZ_O));
            tick();
        end
        set_in(1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("to_error", 32'(outs), 32'(ERR_O));
        tick();
        set_in(1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("to_error_sticky", 32'(outs), 32'(ERR_O));
        tick();
        set_in(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("to_reset", 32'(outs), 32'(RST_O));
        tick();
        set_in(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("post_reset_req", 32'(outs), 32'(FRZ_O));
        tick();
        set_in(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("pending_cleared", 32'(outs), 32'(RUN_O));
        tick();

`ifdef HAZARD_PERF_CNT_EN
        // One load-use hit plus two branches
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("perf_zero", stall_cycles, 32'd0);
        set_in(1'b0, 5'd4, 5'd9, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("perf_stall", stall_cycles, 32'd1);
        check_eq("perf_flush", flush_count, 32'd2);
        check_eq("perf_loaduse", loaduse_count, 32'd1);
`endif

        // Randomized cycles against the model
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                   ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                   ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0);
            check_eq("rand_outs", 32'(outs), 32'(model_out()));
            tick();
        end
`ifdef HAZARD_PERF_CNT_EN
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rand_stall", stall_cycles, m_stall);
        check_eq("rand_flush", flush_count, m_flush);
        check_eq("rand_loaduse", loaduse_count, m_lu);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
